// File: rtl/datacache_pkg.sv
// Shared types and address helpers for the N-way set-associative data cache.
package datacache_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    COMPARE   = 2'd1,
    WRITEBACK = 2'd2,
    FILL      = 2'd3
  } dcache_state_t;

  function automatic logic [31:0] get_tag(input logic [31:0] addr,
                                          input int unsigned s_off,
                                          input int unsigned s_idx);
    return addr >> (s_off + s_idx);
  endfunction

  function automatic logic [31:0] get_index(input logic [31:0] addr,
                                            input int unsigned s_off,
                                            input int unsigned s_idx);
    return (addr >> s_off) & ((32'd1 << s_idx) - 32'd1);
  endfunction

endpackage

// File: rtl/plru_tree.sv
// Tree pseudo-LRU for one set: victim from the current bits, and the updated
// bits after an access. Bit 0 is the root, node i has children 2i+1 / 2i+2.
module plru_tree #(
  parameter int num_ways = 4
) (
  input  logic [num_ways-2:0]         i_bits,
  input  logic [$clog2(num_ways)-1:0] i_way,
  output logic [$clog2(num_ways)-1:0] o_victim,
  output logic [num_ways-2:0]         o_next_bits
);

  localparam int LVL = $clog2(num_ways);

  // A node bit of 0 steers the victim to the left subtree.
  always_comb begin
    logic [LVL:0] node;
    logic         b;
    o_victim = '0;
    node     = '0;
    for (int l = 0; l < LVL; l++) begin
      b                  = i_bits[node];
      o_victim[LVL-1-l]  = b;
      node               = (LVL+1)'(2 * node + 1 + b);
    end
  end

  // Every node on the accessed path is flipped to point away from it.
  always_comb begin
    logic [LVL:0] node;
    logic         d;
    o_next_bits = i_bits;
    node        = '0;
    for (int l = 0; l < LVL; l++) begin
      d                 = i_way[LVL-1-l];
      o_next_bits[node] = ~d;
      node              = (LVL+1)'(2 * node + 1 + d);
    end
  end

endmodule

// File: rtl/datacache_nway.sv
// N-way set-associative write-back / write-allocate L1 data cache with tree PLRU.
// Define DCACHE_PERF_CNT_EN to add saturating hit_count / miss_count outputs.
module datacache_nway
  import datacache_pkg::*;
#(
  parameter int s_offset = 5,
  parameter int s_index  = 3,
  parameter int num_ways = 4,
  parameter int s_tag    = 32 - s_offset - s_index
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          mem_read,
  input  logic          mem_write,
  input  logic [31:0]   mem_address,
  input  logic [255:0]  mem_wdata256,
  input  logic [31:0]   mem_byte_enable256,
  output logic [255:0]  mem_rdata256,
  output logic          mem_resp,
  output logic          pmem_read,
  output logic          pmem_write,
  output logic [31:0]   pmem_address,
  output logic [255:0]  pmem_wdata,
  input  logic [255:0]  pmem_rdata,
  input  logic          pmem_resp,
  output dcache_state_t o_state
`ifdef DCACHE_PERF_CNT_EN
  ,
  output logic [31:0]   hit_count,
  output logic [31:0]   miss_count
`endif
);

  localparam int num_sets = 2 ** s_index;
  localparam int WAY_W    = $clog2(num_ways);

  dcache_state_t r_state, w_next;

  logic [s_index-1:0]  r_index;
  logic [s_tag-1:0]    r_req_tag;
  logic                r_is_write;
  logic [WAY_W-1:0]    r_victim;

  logic                r_valid [num_ways][num_sets];
  logic                r_dirty [num_ways][num_sets];
  logic [s_tag-1:0]    r_tag   [num_ways][num_sets];
  logic [255:0]        r_data  [num_ways][num_sets];
  logic [num_ways-2:0] r_plru  [num_sets];

  logic [num_ways-1:0] w_hit_vec;
  logic                w_hit;
  logic [WAY_W-1:0]    w_hit_way;
  logic                w_inv_found;
  logic [WAY_W-1:0]    w_inv_way;
  logic [WAY_W-1:0]    w_plru_victim;
  logic [WAY_W-1:0]    w_victim;
  logic [num_ways-2:0] w_plru_next;
  logic                w_cmp;
  logic                w_wr_hit;
  logic                w_wb_done;
  logic                w_fill_done;

  always_comb begin
    w_hit_way = '0;
    for (int w = 0; w < num_ways; w++) begin
      w_hit_vec[w] = r_valid[w][r_index] && (r_tag[w][r_index] == r_req_tag);
      if (w_hit_vec[w]) w_hit_way = WAY_W'(w);
    end
    w_hit = |w_hit_vec;
  end

  // Scanning downward lets the lowest-numbered invalid way win.
  always_comb begin
    w_inv_found = 1'b0;
    w_inv_way   = '0;
    for (int w = num_ways - 1; w >= 0; w--) begin
      if (!r_valid[w][r_index]) begin
        w_inv_found = 1'b1;
        w_inv_way   = WAY_W'(w);
      end
    end
  end

  plru_tree #(.num_ways(num_ways)) u_plru (
    .i_bits      (r_plru[r_index]),
    .i_way       (w_hit_way),
    .o_victim    (w_plru_victim),
    .o_next_bits (w_plru_next)
  );

  assign w_victim    = w_inv_found ? w_inv_way : w_plru_victim;
  assign w_cmp       = (r_state == COMPARE);
  assign w_wr_hit    = w_cmp && w_hit && r_is_write;
  assign w_wb_done   = (r_state == WRITEBACK) && pmem_resp;
  assign w_fill_done = (r_state == FILL) && pmem_resp;

  assign mem_rdata256 = r_data[w_hit_way][r_index];
  assign pmem_wdata   = r_data[r_victim][r_index];
  assign o_state      = r_state;

  always_comb begin
    w_next       = r_state;
    mem_resp     = 1'b0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    case (r_state)
      IDLE: begin
        if (mem_read || mem_write) w_next = COMPARE;
      end
      COMPARE: begin
        if (w_hit) begin
          mem_resp = 1'b1;
          w_next   = IDLE;
        end else if (r_valid[w_victim][r_index] && r_dirty[w_victim][r_index]) begin
          w_next = WRITEBACK;
        end else begin
          w_next = FILL;
        end
      end
      WRITEBACK: begin
        pmem_write   = 1'b1;
        pmem_address = {r_tag[r_victim][r_index], r_index, {s_offset{1'b0}}};
        if (pmem_resp) w_next = FILL;
      end
      FILL: begin
        pmem_read    = 1'b1;
        pmem_address = {r_req_tag, r_index, {s_offset{1'b0}}};
        if (pmem_resp) w_next = COMPARE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_index    <= '0;
      r_req_tag  <= '0;
      r_is_write <= 1'b0;
      r_victim   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && (mem_read || mem_write)) begin
        r_index    <= s_index'(get_index(mem_address, s_offset, s_index));
        r_req_tag  <= s_tag'(get_tag(mem_address, s_offset, s_index));
        r_is_write <= mem_write;
      end
      if (w_cmp && !w_hit) r_victim <= w_victim;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int w = 0; w < num_ways; w++) begin
        for (int s = 0; s < num_sets; s++) begin
          r_valid[w][s] <= 1'b0;
          r_dirty[w][s] <= 1'b0;
        end
      end
      for (int s = 0; s < num_sets; s++) r_plru[s] <= '0;
    end else begin
      if (w_fill_done) begin
        r_valid[r_victim][r_index] <= 1'b1;
        r_dirty[r_victim][r_index] <= 1'b0;
      end
      if (w_wb_done) r_dirty[r_victim][r_index] <= 1'b0;
      if (w_cmp && w_hit) r_plru[r_index] <= w_plru_next;
      if (w_wr_hit) r_dirty[w_hit_way][r_index] <= 1'b1;
    end
  end

  // Tag and data storage carry no reset; valid bits gate their use.
  always_ff @(posedge clk) begin
    if (w_fill_done) begin
      r_data[r_victim][r_index] <= pmem_rdata;
      r_tag[r_victim][r_index]  <= r_req_tag;
    end else if (w_wr_hit) begin
      for (int b = 0; b < 32; b++) begin
        if (mem_byte_enable256[b]) r_data[w_hit_way][r_index][8*b +: 8] <= mem_wdata256[8*b +: 8];
      end
    end
  end

`ifdef DCACHE_PERF_CNT_EN
  logic r_first;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_first    <= 1'b0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (r_state == IDLE && (mem_read || mem_write)) r_first <= 1'b1;
      else if (w_cmp && !w_hit) r_first <= 1'b0;
      if (w_cmp && w_hit && r_first && hit_count != 32'hFFFF_FFFF) hit_count <= hit_count + 32'd1;
      if (w_cmp && !w_hit && miss_count != 32'hFFFF_FFFF) miss_count <= miss_count + 32'd1;
    end
  end
`endif

  a_single_hit: assert property (@(posedge clk) disable iff (!rst)
    (r_state == COMPARE) |-> $onehot0(w_hit_vec));

endmodule

// File: tb/tb_datacache_nway.sv
// Scoreboarded bench for datacache_nway: CPU driver, memory responder, response monitor.
module tb_datacache_nway;
  import datacache_pkg::*;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          mem_read = 1'b0;
  logic          mem_write = 1'b0;
  logic [31:0]   mem_address = '0;
  logic [255:0]  mem_wdata256 = '0;
  logic [31:0]   mem_byte_enable256 = '0;
  logic [255:0]  mem_rdata256;
  logic          mem_resp;
  logic          pmem_read;
  logic          pmem_write;
  logic [31:0]   pmem_address;
  logic [255:0]  pmem_wdata;
  logic [255:0]  pmem_rdata;
  logic          pmem_resp;
  dcache_state_t o_state;
`ifdef DCACHE_PERF_CNT_EN
  logic [31:0]   hit_count;
  logic [31:0]   miss_count;
`endif

  datacache_nway dut (
    .clk                (clk),
    .rst                (rst),
    .mem_read           (mem_read),
    .mem_write          (mem_write),
    .mem_address        (mem_address),
    .mem_wdata256       (mem_wdata256),
    .mem_byte_enable256 (mem_byte_enable256),
    .mem_rdata256       (mem_rdata256),
    .mem_resp           (mem_resp),
    .pmem_read          (pmem_read),
    .pmem_write         (pmem_write),
    .pmem_address       (pmem_address),
    .pmem_wdata         (pmem_wdata),
    .pmem_rdata         (pmem_rdata),
    .pmem_resp          (pmem_resp),
    .o_state            (o_state)
`ifdef DCACHE_PERF_CNT_EN
    ,
    .hit_count          (hit_count),
    .miss_count         (miss_count)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [255:0] exp_q[$];
  bit           chk_q[$];
  logic [31:0]  log_addr[$];
  bit           log_wr[$];
  logic [255:0] log_data[$];
  logic [255:0] mem [logic [31:0]];

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic chk256(input string name, input logic [255:0] act, input logic [255:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  function automatic logic [255:0] pat(input logic [31:0] a);
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[32*k +: 32] = (a ^ 32'hC0DE_0000) + 32'(k);
    return l;
  endfunction

  // Memory: answers each pmem request on its third cycle; drops it on reset.
  initial begin : mem_model
    int cnt;
    cnt        = 0;
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    forever begin
      @(negedge clk);
      pmem_resp = 1'b0;
      if (!rst) begin
        cnt = 0;
      end else if (pmem_read || pmem_write) begin
        chk32("pmem_rd_wr_exclusive", 32'(pmem_read & pmem_write), 32'd0);
        cnt++;
        if (cnt == 3) begin
          cnt       = 0;
          pmem_resp = 1'b1;
          if (pmem_write) begin
            mem[pmem_address] = pmem_wdata;
            log_data.push_back(pmem_wdata);
          end else begin
            pmem_rdata = mem.exists(pmem_address) ? mem[pmem_address] : pat(pmem_address);
            log_data.push_back(pmem_rdata);
          end
          log_addr.push_back(pmem_address);
          log_wr.push_back(pmem_write);
        end
      end else begin
        cnt = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst && mem_resp) begin
      chk32("resp_was_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        logic [255:0] e;
        bit           c;
        e = exp_q.pop_front();
        c = chk_q.pop_front();
        if (c) chk256("rdata", mem_rdata256, e);
      end
    end
  end

  task automatic cpu_access(input bit wr, input logic [31:0] addr, input logic [255:0] wd,
                            input logic [31:0] be, input logic [255:0] e, output int cycles);
    bit done;
    done = 1'b0;
    exp_q.push_back(e);
    chk_q.push_back(!wr);
    @(negedge clk);
    mem_address        = addr;
    mem_wdata256       = wd;
    mem_byte_enable256 = be;
    mem_read           = !wr;
    mem_write          = wr;
    cycles             = 1;
    for (int i = 0; i < 100 && !done; i++) begin
      @(posedge clk);
      cycles++;
      @(negedge clk);
      if (mem_resp) done = 1'b1;
    end
    chk32("resp_in_budget", 32'(done), 32'd1);
    if (!done && exp_q.size() > 0) begin
      void'(exp_q.pop_back());
      void'(chk_q.pop_back());
    end
    @(posedge clk);
    #1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [255:0] e, output int cyc);
    cpu_access(1'b0, a, '0, '0, e, cyc);
  endtask

  task automatic wr(input logic [31:0] a, input logic [255:0] d, input logic [31:0] be, output int cyc);
    cpu_access(1'b1, a, d, be, '0, cyc);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int           cyc;
    int           base;
    bit           seen;
    logic [255:0] line;
    logic [255:0] mod_line;
    logic [31:0]  a;

    repeat (3) @(negedge clk);
    chk32("rst_mem_resp",   32'(mem_resp),   32'd0);
    chk32("rst_pmem_read",  32'(pmem_read),  32'd0);
    chk32("rst_pmem_write", 32'(pmem_write), 32'd0);
    chk32("rst_pmem_addr",  pmem_address,    32'd0);
    chk32("rst_state",      32'(o_state),    32'(IDLE));
    rst = 1'b1;

    // Cold read miss, then a hit with no memory traffic.
    base = log_addr.size();
    rd(32'h40, pat(32'h40), cyc);
    chk32("miss_latency", 32'(cyc), 32'd6);
    chk32("miss_n_pmem", 32'(log_addr.size() - base), 32'd1);
    chk32("miss_fill_addr", log_addr[base], 32'h40);
    chk32("miss_fill_is_read", 32'(log_wr[base]), 32'd0);
    base = log_addr.size();
    rd(32'h40, pat(32'h40), cyc);
    chk32("hit_latency", 32'(cyc), 32'd2);

    // Byte-masked write hit.
    line           = {8{32'h1234_5678}};
    line[31:0]     = 32'hDEAD_BEEF;
    mod_line       = pat(32'h40);
    mod_line[31:0] = 32'hDEAD_BEEF;
    wr(32'h40, line, 32'h0000_000F, cyc);
    chk32("write_hit_latency", 32'(cyc), 32'd2);
    rd(32'h40, mod_line, cyc);
    chk32("hits_no_pmem", 32'(log_addr.size() - base), 32'd0);

    // Set 5: fill ways 0..3, fifth tag evicts PLRU way 0 without write-back.
    for (int t = 1; t <= 4; t++) begin
      a = (32'(t) << 8) | 32'hA0;
      rd(a, pat(a), cyc);
    end
    base = log_addr.size();
    rd(32'h5A0, pat(32'h5A0), cyc);
    chk32("clean_evict_n_pmem", 32'(log_addr.size() - base), 32'd1);
    chk32("clean_evict_addr", log_addr[base], 32'h5A0);
    chk32("clean_evict_is_read", 32'(log_wr[base]), 32'd0);
    base = log_addr.size();
    rd(32'h2A0, pat(32'h2A0), cyc);
    rd(32'h3A0, pat(32'h3A0), cyc);
    rd(32'h4A0, pat(32'h4A0), cyc);
    chk32("survivors_hit", 32'(log_addr.size() - base), 32'd0);
    base = log_addr.size();
    rd(32'h1A0, pat(32'h1A0), cyc);
    chk32("evicted_tag_misses", 32'(log_addr.size() - base), 32'd1);

    // Set 2: dirty way 0 becomes PLRU victim after ways 1..3 fill.
    rd(32'h140, pat(32'h140), cyc);
    rd(32'h240, pat(32'h240), cyc);
    rd(32'h340, pat(32'h340), cyc);
    base = log_addr.size();
    rd(32'h440, pat(32'h440), cyc);
    chk32("dirty_evict_n_pmem", 32'(log_addr.size() - base), 32'd2);
    chk32("wb_is_write", 32'(log_wr[base]), 32'd1);
    chk32("wb_addr", log_addr[base], 32'h40);
    chk256("wb_data", log_data[base], mod_line);
    chk32("refill_is_read", 32'(log_wr[base+1]), 32'd0);
    chk32("refill_addr", log_addr[base+1], 32'h440);
    rd(32'h40, mod_line, cyc);

    // Set 7: four dirty lines, then reset in the middle of the write-back.
    for (int t = 0; t < 4; t++) begin
      a = (32'(t) << 8) | 32'hE0;
      wr(a, {8{32'hA5A5_0000 | 32'(t)}}, 32'hFFFF_FFFF, cyc);
    end
    @(negedge clk);
    mem_address = 32'h4E0;
    mem_read    = 1'b1;
    seen        = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (pmem_write) seen = 1'b1;
    end
    chk32("wb_started", 32'(seen), 32'd1);
    chk32("wb7_addr", pmem_address, 32'hE0);
    chk256("wb7_data", pmem_wdata, {8{32'hA5A5_0000}});
    chk32("wb7_no_read", 32'(pmem_read), 32'd0);
    #2;
    rst = 1'b0;
    #1;
    chk32("midrst_mem_resp",   32'(mem_resp),   32'd0);
    chk32("midrst_pmem_read",  32'(pmem_read),  32'd0);
    chk32("midrst_pmem_write", 32'(pmem_write), 32'd0);
    chk32("midrst_pmem_addr",  pmem_address,    32'd0);
    chk32("midrst_state",      32'(o_state),    32'(IDLE));
    mem_read = 1'b0;
    repeat (2) @(negedge clk);
    rst  = 1'b1;
    base = log_addr.size();
    rd(32'hE0, pat(32'hE0), cyc);
    chk32("post_rst_n_pmem", 32'(log_addr.size() - base), 32'd1);
    chk32("post_rst_fill_addr", log_addr[base], 32'hE0);
    chk32("post_rst_is_read", 32'(log_wr[base]), 32'd0);

    // Set 1: three misses then five hits.
    rd(32'h020, pat(32'h020), cyc);
    rd(32'h120, pat(32'h120), cyc);
    rd(32'h220, pat(32'h220), cyc);
    rd(32'h020, pat(32'h020), cyc);
    rd(32'h120, pat(32'h120), cyc);
    rd(32'h220, pat(32'h220), cyc);
    rd(32'h020, pat(32'h020), cyc);
    rd(32'h120, pat(32'h120), cyc);
`ifdef DCACHE_PERF_CNT_EN
    chk32("perf_miss_count", miss_count, 32'd4);
    chk32("perf_hit_count",  hit_count,  32'd5);
`endif

    repeat (5) @(negedge clk);
    chk32("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
